// File: rtl/maze_engine_if.sv
// Region-table configuration bus for maze_engine.
// The master drives one rectangle write per cfg_we strobe.
interface maze_engine_if #(
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned N_REGIONS = 8
);
    localparam int unsigned IdxW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    logic               cfg_we;
    logic [IdxW-1:0]    cfg_idx;
    logic [COORD_W-1:0] cfg_x0;
    logic [COORD_W-1:0] cfg_y0;
    logic [COORD_W-1:0] cfg_x1;
    logic [COORD_W-1:0] cfg_y1;

    modport master (
        output cfg_we,
        output cfg_idx,
        output cfg_x0,
        output cfg_y0,
        output cfg_x1,
        output cfg_y1
    );

    modport slave (
        input cfg_we,
        input cfg_idx,
        input cfg_x0,
        input cfg_y0,
        input cfg_x1,
        input cfg_y1
    );
endinterface

// File: rtl/maze_engine.sv
// Maze game engine: loadable rectangle path, per-frame sequential corner scan,
// goal detection, lives counter and registered colour output.
module maze_engine #(
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned N_REGIONS   = 8,
    parameter int unsigned SQUARE_SIZE = 15,
    parameter int unsigned STEP        = 1,
    parameter int unsigned START_X     = 55,
    parameter int unsigned START_Y     = 55,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned TICK_Y      = 481
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               btn_up_n,
    input  logic               btn_down_n,
    input  logic               btn_left_n,
    input  logic               btn_right_n,
    input  logic               start,
    maze_engine_if.slave       cfg,
    output logic [9:0]         red,
    output logic [9:0]         green,
    output logic [9:0]         blue,
    output logic [2:0]         state,
    output logic [3:0]         lives_left,
    output logic [COORD_W-1:0] sq_x,
    output logic [COORD_W-1:0] sq_y
);
    localparam int unsigned IdxW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam logic [COORD_W-1:0] MaxPos  = COORD_W'((1 << COORD_W) - 1 - SQUARE_SIZE);
    localparam logic [COORD_W-1:0] SqM1    = COORD_W'(SQUARE_SIZE - 1);
    localparam logic [COORD_W-1:0] StepC   = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] StartX  = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] StartY  = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] TickY   = COORD_W'(TICK_Y);
    localparam logic [3:0]         LivesIn = 4'(LIVES);
    localparam logic [IdxW-1:0]    LastIdx = IdxW'(N_REGIONS - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPlay  = 3'd1,
        StCheck = 3'd2,
        StWin   = 3'd3,
        StOver  = 3'd4
    } state_e;

    function automatic logic in_rect(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                     input logic [COORD_W-1:0] rx0, input logic [COORD_W-1:0] ry0,
                                     input logic [COORD_W-1:0] rx1, input logic [COORD_W-1:0] ry1);
        return (px >= rx0) && (px < rx1) && (py >= ry0) && (py < ry1);
    endfunction

    state_e             state_q, state_d;
    logic [3:0]         lives_q, lives_d;
    logic [COORD_W-1:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
    logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [IdxW-1:0]    scan_q, scan_d;
    logic [3:0]         cov_q, cov_d;
    logic               hit_q, hit_d;
    logic               tick_q, tick_d;
    logic [29:0]        rgb_q, rgb_d;

    logic [COORD_W-1:0] rx0_q [N_REGIONS];
    logic [COORD_W-1:0] ry0_q [N_REGIONS];
    logic [COORD_W-1:0] rx1_q [N_REGIONS];
    logic [COORD_W-1:0] ry1_q [N_REGIONS];
    logic [COORD_W-1:0] rx0_d [N_REGIONS];
    logic [COORD_W-1:0] ry0_d [N_REGIONS];
    logic [COORD_W-1:0] rx1_d [N_REGIONS];
    logic [COORD_W-1:0] ry1_d [N_REGIONS];

    logic               cfg_open;
    logic [COORD_W-1:0] next_x, next_y;
    logic [COORD_W:0]   sum_x, sum_y;
    logic [COORD_W-1:0] cx1, cy1;
    logic [3:0]         hits;
    logic [COORD_W:0]   sq_x_end, sq_y_end;
    logic               in_sq, in_goal, in_other;
    logic [2:0]         pix_idx;

    assign cfg_open = (state_q == StIdle) || (state_q == StWin) || (state_q == StOver);

    // Tick is edge-qualified so a held coordinate cannot stretch it.
    always_comb begin
        hit_d  = (y == TickY) && (x == '0);
        tick_d = hit_d && !hit_q;
    end

    always_comb begin
        rx0_d = rx0_q;
        ry0_d = ry0_q;
        rx1_d = rx1_q;
        ry1_d = ry1_q;
        if (cfg.cfg_we && cfg_open && (int'(cfg.cfg_idx) < int'(N_REGIONS))) begin
            rx0_d[cfg.cfg_idx] = cfg.cfg_x0;
            ry0_d[cfg.cfg_idx] = cfg.cfg_y0;
            rx1_d[cfg.cfg_idx] = cfg.cfg_x1;
            ry1_d[cfg.cfg_idx] = cfg.cfg_y1;
        end
    end

    // Candidate position, saturating at both ends of the coordinate range.
    assign sum_x = {1'b0, sq_x_q} + {1'b0, StepC};
    assign sum_y = {1'b0, sq_y_q} + {1'b0, StepC};

    always_comb begin
        next_x = sq_x_q;
        next_y = sq_y_q;
        if (!btn_up_n) begin
            next_y = (sq_y_q < StepC) ? '0 : sq_y_q - StepC;
        end else if (!btn_down_n) begin
            next_y = (sum_y > {1'b0, MaxPos}) ? MaxPos : sum_y[COORD_W-1:0];
        end else if (!btn_left_n) begin
            next_x = (sq_x_q < StepC) ? '0 : sq_x_q - StepC;
        end else if (!btn_right_n) begin
            next_x = (sum_x > {1'b0, MaxPos}) ? MaxPos : sum_x[COORD_W-1:0];
        end
    end

    assign cx1 = cand_x_q + SqM1;
    assign cy1 = cand_y_q + SqM1;

    always_comb begin
        hits[0] = in_rect(cand_x_q, cand_y_q, rx0_q[scan_q], ry0_q[scan_q],
                          rx1_q[scan_q], ry1_q[scan_q]);
        hits[1] = in_rect(cx1, cand_y_q, rx0_q[scan_q], ry0_q[scan_q],
                          rx1_q[scan_q], ry1_q[scan_q]);
        hits[2] = in_rect(cand_x_q, cy1, rx0_q[scan_q], ry0_q[scan_q],
                          rx1_q[scan_q], ry1_q[scan_q]);
        hits[3] = in_rect(cx1, cy1, rx0_q[scan_q], ry0_q[scan_q],
                          rx1_q[scan_q], ry1_q[scan_q]);
    end

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        sq_x_d   = sq_x_q;
        sq_y_d   = sq_y_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        scan_d   = scan_q;
        cov_d    = cov_q;
        unique case (state_q)
            StIdle, StWin, StOver: begin
                if (start) begin
                    state_d = StPlay;
                    lives_d = LivesIn;
                    sq_x_d  = StartX;
                    sq_y_d  = StartY;
                end
            end
            StPlay: begin
                if (tick_q) begin
                    cand_x_d = next_x;
                    cand_y_d = next_y;
                    scan_d   = '0;
                    cov_d    = '0;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                cov_d  = cov_q | hits;
                scan_d = scan_q + IdxW'(1);
                // Last region is the goal; decide the outcome as it is scanned.
                if (scan_q == LastIdx) begin
                    if (&cov_d) begin
                        sq_x_d  = cand_x_q;
                        sq_y_d  = cand_y_q;
                        state_d = (&hits) ? StWin : StPlay;
                    end else begin
                        sq_x_d  = StartX;
                        sq_y_d  = StartY;
                        lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
                        state_d = (lives_d == 4'd0) ? StOver : StPlay;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel classification against the committed square and all regions.
    assign sq_x_end = {1'b0, sq_x_q} + (COORD_W+1)'(SQUARE_SIZE);
    assign sq_y_end = {1'b0, sq_y_q} + (COORD_W+1)'(SQUARE_SIZE);

    always_comb begin
        in_sq = (state_q != StIdle) && (x >= sq_x_q) && ({1'b0, x} < sq_x_end) &&
                (y >= sq_y_q) && ({1'b0, y} < sq_y_end);
        in_goal = in_rect(x, y, rx0_q[N_REGIONS-1], ry0_q[N_REGIONS-1],
                          rx1_q[N_REGIONS-1], ry1_q[N_REGIONS-1]);
        in_other = 1'b0;
        for (int i = 0; i < int'(N_REGIONS) - 1; i++) begin
            in_other = in_other | in_rect(x, y, rx0_q[i], ry0_q[i], rx1_q[i], ry1_q[i]);
        end
        if (in_sq) begin
            pix_idx = 3'd5;
        end else if (in_goal) begin
            pix_idx = 3'd2;
        end else if (in_other) begin
            pix_idx = 3'd7;
        end else begin
            pix_idx = 3'd0;
        end
        rgb_d = {pix_idx[0] ? 10'h3FF : 10'h0E1,
                 pix_idx[1] ? 10'h3FF : 10'h2C2,
                 pix_idx[2] ? 10'h3FF : 10'h37A};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            lives_q  <= '0;
            sq_x_q   <= StartX;
            sq_y_q   <= StartY;
            cand_x_q <= StartX;
            cand_y_q <= StartY;
            scan_q   <= '0;
            cov_q    <= '0;
            hit_q    <= 1'b0;
            tick_q   <= 1'b0;
            rgb_q    <= '0;
            for (int i = 0; i < int'(N_REGIONS); i++) begin
                rx0_q[i] <= '0;
                ry0_q[i] <= '0;
                rx1_q[i] <= '0;
                ry1_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            sq_x_q   <= sq_x_d;
            sq_y_q   <= sq_y_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            scan_q   <= scan_d;
            cov_q    <= cov_d;
            hit_q    <= hit_d;
            tick_q   <= tick_d;
            rgb_q    <= rgb_d;
            for (int i = 0; i < int'(N_REGIONS); i++) begin
                rx0_q[i] <= rx0_d[i];
                ry0_q[i] <= ry0_d[i];
                rx1_q[i] <= rx1_d[i];
                ry1_q[i] <= ry1_d[i];
            end
        end
    end

    assign red        = rgb_q[29:20];
    assign green      = rgb_q[19:10];
    assign blue       = rgb_q[9:0];
    assign state      = state_q;
    assign lives_left = lives_q;
    assign sq_x       = sq_x_q;
    assign sq_y       = sq_y_q;
endmodule

// File: tb/tb_maze_engine.sv
// Directed bench for maze_engine: movement, deaths, goal, colour and reset mid-scan.
module tb_maze_engine;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic       btn_up_n, btn_down_n, btn_left_n, btn_right_n, start;
    logic [9:0] red, green, blue;
    logic [2:0] state;
    logic [3:0] lives_left;
    logic [9:0] sq_x, sq_y;

    int n_checks = 0;
    int n_errors = 0;

    maze_engine_if #(.COORD_W(10), .N_REGIONS(8)) cfg_if ();

    maze_engine dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .btn_up_n    (btn_up_n),
        .btn_down_n  (btn_down_n),
        .btn_left_n  (btn_left_n),
        .btn_right_n (btn_right_n),
        .start       (start),
        .cfg         (cfg_if),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .state       (state),
        .lives_left  (lives_left),
        .sq_x        (sq_x),
        .sq_y        (sq_y)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_region(input int idx, input int x0, input int y0, input int x1,
                                input int y1);
        cfg_if.cfg_idx = 3'(idx);
        cfg_if.cfg_x0  = 10'(x0);
        cfg_if.cfg_y0  = 10'(y0);
        cfg_if.cfg_x1  = 10'(x1);
        cfg_if.cfg_y1  = 10'(y1);
        cfg_if.cfg_we  = 1'b1;
        step(1);
        cfg_if.cfg_we  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_pix(input string tag, input int px, input int py, input int er,
                             input int eg, input int eb);
        x = 10'(px);
        y = 10'(py);
        step(1);
        check_eq({tag, "_r"}, 32'(red), er);
        check_eq({tag, "_g"}, 32'(green), eg);
        check_eq({tag, "_b"}, 32'(blue), eb);
        x = 10'd1000;
        y = 10'd1000;
    endtask

    // Tick pulse then wait out the full scan; commit lands 9 edges after tick.
    task automatic do_tick(input bit chk);
        x = 10'd0;
        y = 10'd481;
        step(1);
        x = 10'd1000;
        y = 10'd1000;
        step(1);
        if (chk) check_eq("scan_entry", 32'(state), 2);
        step(7);
        if (chk) check_eq("scan_hold", 32'(state), 2);
        step(1);
    endtask

    task automatic tick_only();
        x = 10'd0;
        y = 10'd481;
        step(1);
        x = 10'd1000;
        y = 10'd1000;
        step(10);
    endtask

    task automatic die_left(input int exp_lives, input int exp_state);
        btn_left_n = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            do_tick(k == 1);
            check_eq("left_x", 32'(sq_x), (k < 16) ? 55 - k : 55);
        end
        check_eq("death_y", 32'(sq_y), 55);
        check_eq("death_lives", 32'(lives_left), exp_lives);
        check_eq("death_state", 32'(state), exp_state);
    endtask

    initial begin
        reset = 1'b1;
        x = 10'd1000;
        y = 10'd1000;
        {btn_up_n, btn_down_n, btn_left_n, btn_right_n} = 4'hF;
        start = 1'b0;
        cfg_if.cfg_we = 1'b0;
        cfg_if.cfg_idx = '0;
        cfg_if.cfg_x0 = '0;
        cfg_if.cfg_y0 = '0;
        cfg_if.cfg_x1 = '0;
        cfg_if.cfg_y1 = '0;
        step(2);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_lives", 32'(lives_left), 0);
        check_eq("rst_sqx", 32'(sq_x), 55);
        check_eq("rst_sqy", 32'(sq_y), 55);
        check_eq("rst_rgb", {2'b0, red, green, blue}, 0);
        reset = 1'b0;
        step(1);

        // Basic path and colour classes
        write_region(0, 40, 40, 130, 330);
        write_region(7, 40, 300, 130, 330);
        pulse_start();
        check_eq("start_state", 32'(state), 1);
        check_eq("start_lives", 32'(lives_left), 3);
        check_eq("start_sq", {12'b0, sq_x, sq_y}, {12'b0, 10'd55, 10'd55});
        check_pix("pix_path", 100, 100, 'h3FF, 'h3FF, 'h3FF);
        check_pix("pix_bg", 10, 10, 'h0E1, 'h2C2, 'h37A);
        check_pix("pix_sq", 60, 60, 'h3FF, 'h2C2, 'h3FF);

        // Walk down ten ticks
        btn_down_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            do_tick(1'b1);
            check_eq("down_y", 32'(sq_y), 55 + k);
        end
        check_eq("down_x", 32'(sq_x), 55);
        check_eq("down_state", 32'(state), 1);
        btn_down_n = 1'b1;

        // Three deaths walking off the left edge
        die_left(2, 1);
        die_left(1, 1);
        die_left(0, 4);
        tick_only();
        check_eq("over_state", 32'(state), 4);
        check_eq("over_sq", {12'b0, sq_x, sq_y}, {12'b0, 10'd55, 10'd55});
        write_region(1, 0, 0, 40, 40);
        check_pix("pix_over_cfg", 10, 10, 'h3FF, 'h3FF, 'h3FF);
        btn_left_n = 1'b1;
        pulse_start();
        check_eq("restart_state", 32'(state), 1);
        check_eq("restart_lives", 32'(lives_left), 3);

        // Walk into the goal
        btn_down_n = 1'b0;
        for (int k = 1; k <= 245; k++) begin
            do_tick(k == 245);
            if (k == 244) check_eq("pre_goal_state", 32'(state), 1);
        end
        check_eq("win_state", 32'(state), 3);
        check_eq("win_y", 32'(sq_y), 300);
        tick_only();
        check_eq("win_ignore_y", 32'(sq_y), 300);
        check_eq("win_ignore_state", 32'(state), 3);
        btn_down_n = 1'b1;
        check_pix("pix_win_sq", 60, 310, 'h3FF, 'h2C2, 'h3FF);
        check_pix("pix_goal", 50, 320, 'h0E1, 'h3FF, 'h37A);

        // Up beats right, clamp at top, write ignored during play
        write_region(2, 0, 0, 200, 330);
        pulse_start();
        check_eq("start3_sq", {12'b0, sq_x, sq_y}, {12'b0, 10'd55, 10'd55});
        write_region(3, 900, 900, 1000, 1000);
        check_pix("pix_play_cfg", 950, 950, 'h0E1, 'h2C2, 'h37A);
        btn_up_n = 1'b0;
        btn_right_n = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            do_tick(k == 56);
            check_eq("up_y", 32'(sq_y), (k <= 55) ? 55 - k : 0);
        end
        check_eq("up_x", 32'(sq_x), 55);
        check_eq("up_state", 32'(state), 1);

        // Reset in the middle of a scan
        x = 10'd0;
        y = 10'd481;
        step(1);
        x = 10'd1000;
        y = 10'd1000;
        step(3);
        check_eq("mid_scan_state", 32'(state), 2);
        reset = 1'b1;
        #1;
        check_eq("arst_state", 32'(state), 0);
        check_eq("arst_lives", 32'(lives_left), 0);
        check_eq("arst_sq", {12'b0, sq_x, sq_y}, {12'b0, 10'd55, 10'd55});
        check_eq("arst_rgb", {2'b0, red, green, blue}, 0);
        step(1);
        reset = 1'b0;
        {btn_up_n, btn_down_n, btn_left_n, btn_right_n} = 4'hF;
        step(1);
        check_pix("pix_table_clr", 100, 100, 'h0E1, 'h2C2, 'h37A);
        check_eq("post_rst_state", 32'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
